// File: rtl/rans_stream_dec_if.sv
// Handshake bundle for rans_stream_dec: table writes and restart, encoded bytes in,
// decoded symbols out. The slave modport is the decoder side.
interface rans_stream_dec_if #(
   parameter int RESOLUTION   = 10,
   parameter int SYMBOL_WIDTH = 8
);
   logic                    freq_wr_i;
   logic [SYMBOL_WIDTH-1:0] freq_addr_i;
   logic [RESOLUTION:0]     freq_i;
   logic [RESOLUTION-1:0]   cum_freq_i;
   logic                    restart_i;
   logic                    ready_o;
   logic [SYMBOL_WIDTH-1:0] byte_i;
   logic                    byte_valid_i;
   logic                    byte_ready_o;
   logic [SYMBOL_WIDTH-1:0] symb_o;
   logic                    symb_valid_o;
   logic                    symb_ready_i;

   modport slave (
      input  freq_wr_i, freq_addr_i, freq_i, cum_freq_i, restart_i,
      input  byte_i, byte_valid_i, symb_ready_i,
      output ready_o, byte_ready_o, symb_o, symb_valid_o
   );
   modport master (
      output freq_wr_i, freq_addr_i, freq_i, cum_freq_i, restart_i,
      output byte_i, byte_valid_i, symb_ready_i,
      input  ready_o, byte_ready_o, symb_o, symb_valid_o
   );
endinterface

// File: rtl/rans_stream_dec.sv
// Byte-wise single-stream rANS decoder. Consumes the encoder's bytes in reverse order
// and resolves each symbol through a slot-to-symbol table filled from the freq writes.
module rans_stream_dec #(
   parameter int RESOLUTION   = 10,
   parameter int SYMBOL_WIDTH = 8,
   parameter int STATE_WIDTH  = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   rans_stream_dec_if.slave bus
);
   localparam int M     = 1 << RESOLUTION;
   localparam int NSYM  = 1 << SYMBOL_WIDTH;
   localparam int NLOAD = STATE_WIDTH / SYMBOL_WIDTH;
   localparam int PW    = STATE_WIDTH + RESOLUTION + 1;
   localparam logic [STATE_WIDTH-1:0] L_BOUND   = STATE_WIDTH'(1) << (STATE_WIDTH - SYMBOL_WIDTH);
   localparam logic [RESOLUTION:0]    LOAD_LAST = (RESOLUTION+1)'(NLOAD - 1);

   typedef enum logic [3:0] {
      S_IDLE, S_FILL, S_LOAD, S_LOOKUP, S_RD_SLOT, S_RD_FREQ, S_CALC, S_RENORM, S_EMIT
   } state_t;

   state_t                  state_q, state_d;
   logic [STATE_WIDTH-1:0]  x_q, x_d;
   logic [RESOLUTION:0]     cnt_q, cnt_d, freq_q, freq_d;
   logic [RESOLUTION-1:0]   cum_q, cum_d;
   logic [SYMBOL_WIDTH-1:0] sym_q, sym_d, symb_q, symb_d;
   logic                    ft_we, ft_re, slot_we, slot_re;
   logic                    x_low;
   logic [RESOLUTION-1:0]   slot_waddr;
   logic [PW-1:0]           calc_x;

   logic [2*RESOLUTION:0]   ft_mem [NSYM];
   logic [2*RESOLUTION:0]   ft_rdata_q;
   logic [SYMBOL_WIDTH-1:0] slot_mem [M];
   logic [SYMBOL_WIDTH-1:0] slot_rdata_q;

   assign x_low      = x_q < L_BOUND;
   assign slot_waddr = cum_q + cnt_q[RESOLUTION-1:0];
   assign calc_x     = PW'(freq_q) * PW'(x_q >> RESOLUTION) + PW'(x_q[RESOLUTION-1:0]) - PW'(cum_q);

   // freq/cum and slot tables: one write port, one registered read port each
   always_ff @(posedge clk_i) begin
      if (ft_we) ft_mem[bus.freq_addr_i] <= {bus.freq_i, bus.cum_freq_i};
      if (ft_re) ft_rdata_q <= ft_mem[slot_rdata_q];
   end

   always_ff @(posedge clk_i) begin
      if (slot_we) slot_mem[slot_waddr] <= sym_q;
      if (slot_re) slot_rdata_q <= slot_mem[x_q[RESOLUTION-1:0]];
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         x_q     <= '0;
         cnt_q   <= '0;
         freq_q  <= '0;
         cum_q   <= '0;
         sym_q   <= '0;
         symb_q  <= '0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         cnt_q   <= cnt_d;
         freq_q  <= freq_d;
         cum_q   <= cum_d;
         sym_q   <= sym_d;
         symb_q  <= symb_d;
      end
   end

   // freq_q/cum_q/sym_q hold the fill parameters in FILL and the looked-up entry while decoding
   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      cnt_d   = cnt_q;
      freq_d  = freq_q;
      cum_d   = cum_q;
      sym_d   = sym_q;
      symb_d  = symb_q;
      ft_we   = 1'b0;
      ft_re   = 1'b0;
      slot_we = 1'b0;
      slot_re = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.restart_i) begin
               state_d = S_LOAD;
               x_d     = '0;
               cnt_d   = '0;
            end else if (bus.freq_wr_i) begin
               ft_we  = 1'b1;
               sym_d  = bus.freq_addr_i;
               freq_d = bus.freq_i;
               cum_d  = bus.cum_freq_i;
               cnt_d  = '0;
               if (bus.freq_i != '0) state_d = S_FILL;
            end
         end
         S_FILL: begin
            slot_we = 1'b1;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == freq_q - 1'b1) state_d = S_IDLE;
         end
         S_LOAD: begin
            if (bus.byte_valid_i) begin
               x_d   = {x_q[STATE_WIDTH-SYMBOL_WIDTH-1:0], bus.byte_i};
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == LOAD_LAST) state_d = S_LOOKUP;
            end
         end
         S_LOOKUP: begin
            slot_re = 1'b1;
            state_d = S_RD_SLOT;
         end
         S_RD_SLOT: begin
            ft_re   = 1'b1;
            state_d = S_RD_FREQ;
         end
         S_RD_FREQ: begin
            sym_d   = slot_rdata_q;
            freq_d  = ft_rdata_q[2*RESOLUTION:RESOLUTION];
            cum_d   = ft_rdata_q[RESOLUTION-1:0];
            state_d = S_CALC;
         end
         S_CALC: begin
            x_d     = calc_x[STATE_WIDTH-1:0];
            symb_d  = sym_q;
            state_d = S_RENORM;
         end
         S_RENORM: begin
            if (!x_low)                 state_d = S_EMIT;
            else if (bus.byte_valid_i)  x_d = {x_q[STATE_WIDTH-SYMBOL_WIDTH-1:0], bus.byte_i};
         end
         S_EMIT: begin
            if (bus.symb_ready_i) state_d = S_LOOKUP;
         end
         default: state_d = S_IDLE;
      endcase
      if (bus.restart_i && (state_q inside {S_LOOKUP, S_RD_SLOT, S_RD_FREQ, S_CALC, S_RENORM, S_EMIT})) begin
         state_d = S_LOAD;
         x_d     = '0;
         cnt_d   = '0;
      end
   end

   always_comb begin
      bus.ready_o      = 1'b0;
      bus.byte_ready_o = 1'b0;
      bus.symb_valid_o = 1'b0;
      case (state_q)
         S_IDLE:   bus.ready_o = 1'b1;
         S_LOAD:   bus.byte_ready_o = 1'b1;
         S_LOOKUP, S_RD_SLOT, S_RD_FREQ, S_CALC: bus.ready_o = 1'b1;
         S_RENORM: begin
            bus.ready_o      = 1'b1;
            bus.byte_ready_o = x_low;
         end
         S_EMIT: begin
            bus.ready_o      = 1'b1;
            bus.symb_valid_o = 1'b1;
         end
         default: ;
      endcase
   end

   assign bus.symb_o = symb_q;

endmodule

// File: tb/tb_rans_stream_dec.sv
// Bench for rans_stream_dec: directed fill/reset/backpressure/restart cases plus
// random-table round trips through a software rANS encoder with a symbol scoreboard.
module tb_rans_stream_dec;
   localparam int R  = 10;
   localparam int SW = 8;
   localparam int XW = 32;
   localparam longint LB = 64'd1 << (XW - SW);

   logic clk = 1'b0;
   logic rst = 1'b1;

   rans_stream_dec_if #(.RESOLUTION(R), .SYMBOL_WIDTH(SW)) bus ();
   rans_stream_dec #(.RESOLUTION(R), .SYMBOL_WIDTH(SW), .STATE_WIDTH(XW)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;
   int tf [256];
   int tc [256];
   int syms_act [$];
   logic [7:0] byte_q [$];
   logic [7:0] exp_q [$];
   bit rx_done;

   task automatic chk(input string tag, input longint got, input longint exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic wait_ready();
      int k = 0;
      while (!bus.ready_o && k < 4000) begin @(negedge clk); k++; end
      chk("rdy_tmo", bus.ready_o, 1);
   endtask

   task automatic wait_sv();
      int k = 0;
      while (!bus.symb_valid_o && k < 500) begin @(negedge clk); k++; end
      chk("sv_tmo", bus.symb_valid_o, 1);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic wr_freq(input int s, input int f, input int c);
      wait_ready();
      bus.freq_wr_i   = 1'b1;
      bus.freq_addr_i = 8'(s);
      bus.freq_i      = 11'(f);
      bus.cum_freq_i  = 10'(c);
      @(negedge clk);
      bus.freq_wr_i   = 1'b0;
   endtask

   task automatic load_table();
      foreach (syms_act[i]) wr_freq(syms_act[i], tf[syms_act[i]], tc[syms_act[i]]);
      wait_ready();
   endtask

   task automatic pulse_restart();
      wait_ready();
      bus.restart_i = 1'b1;
      @(negedge clk);
      bus.restart_i = 1'b0;
   endtask

   task automatic feed(input logic [7:0] b);
      int k = 0;
      bus.byte_i       = b;
      bus.byte_valid_i = 1'b1;
      while (!bus.byte_ready_o && k < 200) begin @(negedge clk); k++; end
      chk("feed_tmo", bus.byte_ready_o, 1);
      @(negedge clk);
      bus.byte_valid_i = 1'b0;
   endtask

   task automatic set_ab();
      syms_act = '{8'h41, 8'h42};
      tf[8'h41] = 512; tc[8'h41] = 0;
      tf[8'h42] = 512; tc[8'h42] = 512;
   endtask

   task automatic rand_table();
      int n, base, rem, e, cum;
      syms_act.delete();
      n    = $urandom_range(2, 12);
      base = $urandom_range(0, 255);
      rem  = 1024 - n;
      cum  = 0;
      for (int i = 0; i < n; i++) begin
         int s;
         s = (base + i * 19) & 255;
         e = (i == n - 1) ? rem : $urandom_range(0, rem);
         rem -= e;
         tf[s] = 1 + e;
         tc[s] = cum;
         cum  += tf[s];
         syms_act.push_back(s);
      end
   endtask

   // encodes symbols last-to-first; bytes are pushed to the front so the queue holds
   // the reversed emission order the decoder expects
   task automatic encode(input int n);
      longint x, f, c, xmax;
      int seq [];
      seq = new[n];
      for (int i = 0; i < n; i++) begin
         seq[i] = syms_act[$urandom_range(0, syms_act.size() - 1)];
         exp_q.push_back(8'(seq[i]));
      end
      x = LB;
      for (int i = n - 1; i >= 0; i--) begin
         f    = tf[seq[i]];
         c    = tc[seq[i]];
         xmax = ((LB >> R) << SW) * f;
         while (x >= xmax) begin
            byte_q.push_front(8'(x & 255));
            x = x >> 8;
         end
         x = ((x / f) << R) + (x % f) + c;
      end
      for (int k = 0; k < 4; k++) begin
         byte_q.push_front(8'(x & 255));
         x = x >> 8;
      end
   endtask

   task automatic run_stream(input int nsym, input int left_exp);
      pulse_restart();
      chk("rs_sv", bus.symb_valid_o, 0);
      rx_done = 1'b0;
      fork
         begin : drv
            int cyc = 0;
            int tail = 0;
            while (tail < 10 && cyc < 60000) begin
               bus.byte_valid_i = (byte_q.size() > 0) && ($urandom_range(0, 99) < 70);
               bus.byte_i       = (byte_q.size() > 0) ? byte_q[0] : 8'h00;
               if (bus.byte_valid_i && bus.byte_ready_o) void'(byte_q.pop_front());
               @(negedge clk);
               cyc++;
               if (rx_done) tail++;
            end
            bus.byte_valid_i = 1'b0;
         end
         begin : rcv
            int got = 0;
            int cyc = 0;
            bit pend = 1'b0;
            logic [7:0] prev = 8'h00;
            while (got < nsym && cyc < 60000) begin
               if (pend) chk("hold", {bus.symb_valid_o, bus.symb_o}, {1'b1, prev});
               bus.symb_ready_i = ($urandom_range(0, 99) < 60);
               if (bus.symb_valid_o && bus.symb_ready_i) begin
                  chk("sym", bus.symb_o, exp_q.pop_front());
                  got++;
               end
               pend = bus.symb_valid_o && !bus.symb_ready_i;
               prev = bus.symb_o;
               @(negedge clk);
               cyc++;
            end
            bus.symb_ready_i = 1'b0;
            chk("sym_cnt", got, nsym);
            rx_done = 1'b1;
         end
      join
      chk("bytes_left", byte_q.size(), left_exp);
      exp_q.delete();
      byte_q.delete();
   endtask

   initial begin
      int lows;
      bus.freq_wr_i = 0; bus.freq_addr_i = 0; bus.freq_i = 0; bus.cum_freq_i = 0;
      bus.restart_i = 0; bus.byte_i = 0; bus.byte_valid_i = 0; bus.symb_ready_i = 0;
      repeat (3) @(negedge clk);
      chk("rst_rdy", bus.ready_o, 1);
      chk("rst_brdy", bus.byte_ready_o, 0);
      chk("rst_sv", bus.symb_valid_o, 0);
      chk("rst_sym", bus.symb_o, 0);
      rst = 1'b0;
      @(negedge clk);

      // fill timing: freq 4 keeps ready low for exactly 4 cycles
      wait_ready();
      bus.freq_wr_i = 1'b1; bus.freq_addr_i = 8'h41; bus.freq_i = 11'd4; bus.cum_freq_i = 10'd8;
      @(negedge clk);
      bus.freq_wr_i = 1'b0;
      lows = 0;
      while (!bus.ready_o && lows < 100) begin lows++; @(negedge clk); end
      chk("fill_low", lows, 4);
      byte_q = '{8'h01, 8'h00, 8'h00, 8'h09, 8'h00};
      exp_q.push_back(8'h41);
      run_stream(1, 0);

      // reset in the middle of LOAD
      pulse_restart();
      bus.byte_i = 8'h11; bus.byte_valid_i = 1'b1;
      repeat (2) @(negedge clk);
      bus.byte_valid_i = 1'b0;
      chk("load_brdy", bus.byte_ready_o, 1);
      rst = 1'b1;
      #1;
      chk("mid_rdy", bus.ready_o, 1);
      chk("mid_brdy", bus.byte_ready_o, 0);
      chk("mid_sv", bus.symb_valid_o, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // single decode; the trailing byte must stay unconsumed (next renorm needs none)
      set_ab();
      load_table();
      byte_q = '{8'h00, 8'h80, 8'h00, 8'h00, 8'h12, 8'hAB};
      exp_q.push_back(8'h41);
      run_stream(1, 1);

      // backpressure in EMIT
      pulse_restart();
      @(negedge clk);
      chk("abort_sv", bus.symb_valid_o, 0);
      feed(8'h00); feed(8'h80); feed(8'h00); feed(8'h00); feed(8'h12);
      wait_sv();
      for (int i = 0; i < 5; i++) begin
         chk("bp_sv", bus.symb_valid_o, 1);
         chk("bp_sym", bus.symb_o, 8'h41);
         chk("bp_brdy", bus.byte_ready_o, 0);
         @(negedge clk);
      end
      bus.symb_ready_i = 1'b1;
      @(negedge clk);
      bus.symb_ready_i = 1'b0;
      chk("bp_drop", bus.symb_valid_o, 0);
      wait_sv();
      chk("bp_sym2", bus.symb_o, 8'h41);

      // restart while RENORM waits for a byte
      pulse_restart();
      feed(8'h00); feed(8'h80); feed(8'h00); feed(8'h00);
      repeat (6) @(negedge clk);
      chk("rn_brdy", bus.byte_ready_o, 1);
      chk("rn_sv", bus.symb_valid_o, 0);
      encode(50);
      run_stream(50, 0);

      // random-table round trips
      for (int t = 0; t < 4; t++) begin
         do_reset();
         rand_table();
         load_table();
         encode(1000);
         run_stream(1000, 0);
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
